// File: rtl/spi_slave_rx.sv
// Mode-0 SPI responder: oversamples sclk/mosi/cs in the clk domain, receives one WIDTH-bit word per cs frame.
// Optional frame_error reporting is enabled by defining SPI_SLAVE_FRAME_ERR_EN.
module spi_slave_rx #(
   parameter int unsigned WIDTH       = 16,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] data_to_tx,
   output logic [WIDTH-1:0] data_rx,
   output logic             transfer_done,
   output logic             transfer_busy,
   output logic             tx_latched,
`ifdef SPI_SLAVE_FRAME_ERR_EN
   output logic             frame_error,
`endif
   input  logic             sclk,
   input  logic             mosi,
   input  logic             cs,
   output logic             miso
);

   localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2,
      WAIT  = 2'd3
   } state_t;

   state_t                 state;
   logic [SYNC_STAGES-1:0] sclk_sync;
   logic [SYNC_STAGES-1:0] mosi_sync;
   logic [SYNC_STAGES-1:0] cs_sync;
   logic                   sclk_d;
   logic                   cs_d;
   logic [WIDTH-1:0]       rx_shift;
   logic [WIDTH-2:0]       tx_shift;
   logic [CNT_W-1:0]       bit_cnt;

   logic sclk_s, mosi_s, cs_s;
   logic sclk_rise, sclk_fall, cs_rise, cs_fall;

   assign sclk_s    = sclk_sync[SYNC_STAGES-1];
   assign mosi_s    = mosi_sync[SYNC_STAGES-1];
   assign cs_s      = cs_sync[SYNC_STAGES-1];
   assign sclk_rise =  sclk_s & ~sclk_d;
   assign sclk_fall = ~sclk_s &  sclk_d;
   assign cs_rise   =  cs_s   & ~cs_d;
   assign cs_fall   = ~cs_s   &  cs_d;

   // tx_shift only holds the bits still to be sent; the MSB goes straight to miso at frame start
   always_ff @(posedge clk) begin
      if (reset) begin
         sclk_sync     <= '0;
         mosi_sync     <= '0;
         cs_sync       <= '0;
         sclk_d        <= 1'b0;
         cs_d          <= 1'b0;
         state         <= IDLE;
         rx_shift      <= '0;
         tx_shift      <= '0;
         bit_cnt       <= '0;
         data_rx       <= '0;
         transfer_done <= 1'b0;
         transfer_busy <= 1'b0;
         tx_latched    <= 1'b0;
         miso          <= 1'b0;
`ifdef SPI_SLAVE_FRAME_ERR_EN
         frame_error   <= 1'b0;
`endif
      end else begin
         sclk_sync     <= {sclk_sync[SYNC_STAGES-2:0], sclk};
         mosi_sync     <= {mosi_sync[SYNC_STAGES-2:0], mosi};
         cs_sync       <= {cs_sync[SYNC_STAGES-2:0], cs};
         sclk_d        <= sclk_s;
         cs_d          <= cs_s;
         transfer_done <= 1'b0;
         tx_latched    <= 1'b0;
`ifdef SPI_SLAVE_FRAME_ERR_EN
         frame_error   <= 1'b0;
`endif
         case (state)
            IDLE: begin
               if (cs_fall) begin
                  state         <= SHIFT;
                  tx_shift      <= data_to_tx[WIDTH-2:0];
                  miso          <= data_to_tx[WIDTH-1];
                  tx_latched    <= 1'b1;
                  bit_cnt       <= '0;
                  transfer_busy <= 1'b1;
               end
            end
            SHIFT: begin
               if (cs_rise) begin
                  state         <= IDLE;
                  transfer_busy <= 1'b0;
                  miso          <= 1'b0;
`ifdef SPI_SLAVE_FRAME_ERR_EN
                  frame_error   <= 1'b1;
`endif
               end else begin
                  if (sclk_rise) begin
                     rx_shift <= {rx_shift[WIDTH-2:0], mosi_s};
                     bit_cnt  <= bit_cnt + CNT_W'(1);
                     if (bit_cnt == CNT_W'(WIDTH - 1)) state <= DONE;
                  end
                  if (sclk_fall) begin
                     tx_shift <= {tx_shift[WIDTH-3:0], 1'b0};
                     miso     <= tx_shift[WIDTH-2];
                  end
               end
            end
            DONE: begin
               data_rx       <= rx_shift;
               transfer_done <= 1'b1;
               miso          <= 1'b0;
               state         <= WAIT;
            end
            WAIT: begin
               // level test also covers a cs rise that landed during the single DONE cycle
               if (cs_s) begin
                  state         <= IDLE;
                  transfer_busy <= 1'b0;
               end else if (sclk_rise) begin
`ifdef SPI_SLAVE_FRAME_ERR_EN
                  frame_error <= 1'b1;
`endif
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_spi_slave_rx.sv
// Directed bench for spi_slave_rx: a cycle-timed mode-0 master drives frames and captures miso.
module tb_spi_slave_rx;
   localparam int unsigned HALF = 4;

   logic        clk = 1'b0;
   logic        reset, sclk, mosi, cs;
   logic [15:0] data_to_tx, data_rx;
   logic        transfer_done, transfer_busy, tx_latched, miso;
`ifdef SPI_SLAVE_FRAME_ERR_EN
   logic        frame_error;
`endif

   int checks = 0, errors = 0;
   int done_cnt = 0, latch_cnt = 0, ferr_cnt = 0;
   int d0, l0, f0;
   logic [15:0] cap;
   logic        m;

   always #5 clk = ~clk;

   spi_slave_rx #(.WIDTH(16), .SYNC_STAGES(2)) dut (
      .clk           (clk),
      .reset         (reset),
      .data_to_tx    (data_to_tx),
      .data_rx       (data_rx),
      .transfer_done (transfer_done),
      .transfer_busy (transfer_busy),
      .tx_latched    (tx_latched),
`ifdef SPI_SLAVE_FRAME_ERR_EN
      .frame_error   (frame_error),
`endif
      .sclk          (sclk),
      .mosi          (mosi),
      .cs            (cs),
      .miso          (miso)
   );

   // pulse counters, sampled mid-cycle
   always @(negedge clk) begin
      if (transfer_done) done_cnt++;
      if (tx_latched) latch_cnt++;
`ifdef SPI_SLAVE_FRAME_ERR_EN
      if (frame_error) ferr_cnt++;
`endif
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic cs_start();
      cs = 1'b0;
      wait_clk(HALF);
   endtask

   task automatic cs_end();
      wait_clk(HALF);
      cs = 1'b1;
      wait_clk(HALF);
   endtask

   // one sclk period: data set in the low phase, miso sampled at the rising edge
   task automatic send_bit(input logic b, output logic sampled);
      mosi = b;
      wait_clk(HALF);
      sclk = 1'b1;
      sampled = miso;
      wait_clk(HALF);
      sclk = 1'b0;
   endtask

   task automatic frame(input logic [15:0] word, input int nbits, output logic [15:0] got_miso);
      logic b, s;
      got_miso = '0;
      cs_start();
      for (int i = 0; i < nbits; i++) begin
         b = (i < 16) ? word[15-i] : 1'b0;
         send_bit(b, s);
         if (i < 16) got_miso[15-i] = s;
      end
      cs_end();
   endtask

   initial begin
      reset = 1'b1; cs = 1'b1; sclk = 1'b0; mosi = 1'b0; data_to_tx = '0;
      wait_clk(3);
      reset = 1'b0;
      wait_clk(1);
      check("rst_data_rx", 32'(data_rx), 32'h0);
      check("rst_done", 32'(transfer_done), 32'h0);
      check("rst_busy", 32'(transfer_busy), 32'h0);
      check("rst_latched", 32'(tx_latched), 32'h0);
      check("rst_miso", 32'(miso), 32'h0);

      // sclk activity with cs high must be ignored
      d0 = done_cnt; l0 = latch_cnt;
      for (int i = 0; i < 4; i++) send_bit(1'b1, m);
      wait_clk(HALF);
      check("idle_sclk_done", 32'(done_cnt - d0), 32'd0);
      check("idle_sclk_latch", 32'(latch_cnt - l0), 32'd0);
      check("idle_sclk_busy", 32'(transfer_busy), 32'h0);
      check("idle_sclk_miso", 32'(miso), 32'h0);

      // single frame
      data_to_tx = 16'h0019;
      d0 = done_cnt; l0 = latch_cnt;
      frame(16'hA55A, 16, cap);
      check("single_data_rx", 32'(data_rx), 32'hA55A);
      check("single_miso", 32'(cap), 32'h0019);
      check("single_done", 32'(done_cnt - d0), 32'd1);
      check("single_latch", 32'(latch_cnt - l0), 32'd1);
      check("single_busy_after", 32'(transfer_busy), 32'h0);
      check("single_miso_idle", 32'(miso), 32'h0);

      // back-to-back, data_to_tx changed mid-frame
      data_to_tx = 16'h1111;
      d0 = done_cnt; l0 = latch_cnt;
      cap = '0;
      cs_start();
      for (int i = 0; i < 16; i++) begin
         logic [15:0] w;
         w = 16'h1234;
         if (i == 8) begin
            data_to_tx = 16'h2222;
            check("b2b_busy_mid", 32'(transfer_busy), 32'h1);
         end
         send_bit(w[15-i], m);
         cap[15-i] = m;
      end
      cs_end();
      check("b2b1_data_rx", 32'(data_rx), 32'h1234);
      check("b2b1_miso", 32'(cap), 32'h1111);
      frame(16'hFFFF, 16, cap);
      check("b2b2_data_rx", 32'(data_rx), 32'hFFFF);
      check("b2b2_miso", 32'(cap), 32'h2222);
      check("b2b_done", 32'(done_cnt - d0), 32'd2);
      check("b2b_latch", 32'(latch_cnt - l0), 32'd2);

      // abort after 7 bits, then a good frame
      d0 = done_cnt; f0 = ferr_cnt;
      frame(16'h1357, 7, cap);
      check("abort_data_rx", 32'(data_rx), 32'hFFFF);
      check("abort_done", 32'(done_cnt - d0), 32'd0);
      check("abort_busy", 32'(transfer_busy), 32'h0);
`ifdef SPI_SLAVE_FRAME_ERR_EN
      check("abort_ferr", 32'(ferr_cnt - f0), 32'd1);
`endif
      d0 = done_cnt;
      frame(16'h00FF, 16, cap);
      check("post_abort_data_rx", 32'(data_rx), 32'h00FF);
      check("post_abort_done", 32'(done_cnt - d0), 32'd1);

      // 18 clocks in one frame
      data_to_tx = 16'h8001;
      d0 = done_cnt; f0 = ferr_cnt;
      frame(16'hC3A5, 18, cap);
      check("extra_data_rx", 32'(data_rx), 32'hC3A5);
      check("extra_done", 32'(done_cnt - d0), 32'd1);
      check("extra_miso", 32'(cap), 32'h8001);
`ifdef SPI_SLAVE_FRAME_ERR_EN
      check("extra_ferr", 32'(ferr_cnt - f0), 32'd2);
`endif

      // reset after 9 bits with cs still low
      d0 = done_cnt; l0 = latch_cnt; f0 = ferr_cnt;
      cs_start();
      for (int i = 0; i < 9; i++) send_bit(1'b1, m);
      check("midrst_busy_before", 32'(transfer_busy), 32'h1);
      reset = 1'b1;
      wait_clk(1);
      reset = 1'b0;
      wait_clk(1);
      check("midrst_data_rx", 32'(data_rx), 32'h0);
      check("midrst_busy", 32'(transfer_busy), 32'h0);
      check("midrst_miso", 32'(miso), 32'h0);
      for (int i = 0; i < 7; i++) send_bit(1'b1, m);
      wait_clk(HALF);
      check("midrst_rest_done", 32'(done_cnt - d0), 32'd0);
      check("midrst_rest_data_rx", 32'(data_rx), 32'h0);
      check("midrst_rest_busy", 32'(transfer_busy), 32'h0);
      check("midrst_latch", 32'(latch_cnt - l0), 32'd1);
`ifdef SPI_SLAVE_FRAME_ERR_EN
      check("midrst_ferr", 32'(ferr_cnt - f0), 32'd0);
`endif
      cs = 1'b1;
      wait_clk(HALF);
      frame(16'hBEEF, 16, cap);
      check("midrst_new_data_rx", 32'(data_rx), 32'hBEEF);
      check("midrst_new_done", 32'(done_cnt - d0), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
